// File: rtl/majority_operand_loader_if.sv
// Handshake bundle between the operand stream source, the loader and the majority stage.
// The master modport is the source/sink side; the slave modport is the loader itself.
interface majority_operand_loader_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_tag;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_valid;
  logic             op_ready;

  modport master (
    output in_data,
    output in_tag,
    output in_valid,
    output op_ready,
    input  in_ready,
    input  op_a,
    input  op_b,
    input  op_valid
  );

  modport slave (
    input  in_data,
    input  in_tag,
    input  in_valid,
    input  op_ready,
    output in_ready,
    output op_a,
    output op_b,
    output op_valid
  );
endinterface

// File: rtl/majority_operand_loader.sv
// Captures alternate stream beats as operands A and B and holds the pair stable for the
// majority stage. Optional tag order check enabled by defining MAJ_LOADER_ORDER_CHECK_EN.
module majority_operand_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  majority_operand_loader_if.slave          bus,
  input  logic                              abort,
  output logic [7:0]                        pair_count,
  output logic                              order_err
);

  typedef enum logic [1:0] {
    StLoadA = 2'd0,
    StLoadB = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             op_valid_q, op_valid_d;

  logic             accept;
  logic             tag_bad_a;
  logic             tag_bad_b;

  assign accept = bus.in_valid && in_ready_q;

`ifdef MAJ_LOADER_ORDER_CHECK_EN
  assign tag_bad_a = bus.in_tag;
  assign tag_bad_b = !bus.in_tag;
`else
  logic unused_in_tag;
  assign unused_in_tag = bus.in_tag;
  assign tag_bad_a     = 1'b0;
  assign tag_bad_b     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      StLoadA: begin
        if (accept) begin
          // A mistagged beat is consumed but dropped; the state does not advance.
          if (tag_bad_a) begin
            err_d = 1'b1;
          end else begin
            op_a_d  = bus.in_data;
            state_d = StLoadB;
          end
        end
      end
      StLoadB: begin
        // Abort wins over a coincident beat: the partial A is discarded, B untouched.
        if (abort) begin
          state_d = StLoadA;
        end else if (accept) begin
          if (tag_bad_b) begin
            err_d = 1'b1;
          end else begin
            op_b_d  = bus.in_data;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (bus.op_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StLoadA;
        end
      end
      default: begin
        state_d = StLoadA;
      end
    endcase
    in_ready_d = (state_d != StHold);
    op_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoadA;
      op_a_q     <= '0;
      op_b_q     <= '0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.op_valid = op_valid_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign pair_count   = cnt_q;
  assign order_err    = err_q;

  a_pair_stable: assert property (@(posedge clk) disable iff (rst)
    (op_valid_q && !bus.op_ready) |=> (op_valid_q && $stable(op_a_q) && $stable(op_b_q)));

  a_ready_valid_excl: assert property (@(posedge clk) disable iff (rst)
    (in_ready_q != op_valid_q));

endmodule

// File: tb/tb_majority_operand_loader.sv
// Directed, table-driven bench for majority_operand_loader, plus hand-written sequences
// for counter wrap, reset during HOLD and the tag order check.
module tb_majority_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic [7:0] pair_count;
  logic       order_err;

  always #5 clk = ~clk;

  majority_operand_loader_if #(.WIDTH(8)) bus ();

  majority_operand_loader #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .abort      (abort),
    .pair_count (pair_count),
    .order_err  (order_err)
  );

  typedef struct {
    logic       ab;
    logic       iv;
    logic [7:0] d;
    logic       t;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] cnt;
  } vec_t;

  localparam int NumVec = 22;
  vec_t vecs[NumVec];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ab, input logic iv, input logic [7:0] d, input logic t,
                       input logic ordy);
    abort        = ab;
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.in_tag   = t;
    bus.op_ready = ordy;
  endtask

  task automatic check_all(input string name, input logic ir, input logic ov,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] cnt);
    check({name, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, ir});
    check({name, ".op_valid"}, {31'd0, bus.op_valid}, {31'd0, ov});
    check({name, ".op_a"}, {24'd0, bus.op_a}, {24'd0, a});
    check({name, ".op_b"}, {24'd0, bus.op_b}, {24'd0, b});
    check({name, ".pair_count"}, {24'd0, pair_count}, {24'd0, cnt});
  endtask

  initial begin
    //            ab iv data   tg rdy | ir ov a      b      cnt
    vecs[0]  = '{0, 1, 8'hCC, 0, 1,   1, 0, 8'hCC, 8'h00, 8'd0};
    vecs[1]  = '{0, 1, 8'hAA, 1, 1,   0, 1, 8'hCC, 8'hAA, 8'd0};
    vecs[2]  = '{0, 0, 8'h00, 0, 1,   1, 0, 8'hCC, 8'hAA, 8'd1};
    vecs[3]  = '{0, 1, 8'h01, 0, 0,   1, 0, 8'h01, 8'hAA, 8'd1};
    vecs[4]  = '{0, 1, 8'h00, 1, 0,   0, 1, 8'h01, 8'h00, 8'd1};
    vecs[5]  = '{0, 1, 8'h77, 0, 0,   0, 1, 8'h01, 8'h00, 8'd1};
    vecs[6]  = '{0, 1, 8'h77, 0, 0,   0, 1, 8'h01, 8'h00, 8'd1};
    vecs[7]  = '{0, 1, 8'h77, 0, 0,   0, 1, 8'h01, 8'h00, 8'd1};
    vecs[8]  = '{0, 1, 8'h77, 0, 0,   0, 1, 8'h01, 8'h00, 8'd1};
    vecs[9]  = '{0, 1, 8'h77, 0, 0,   0, 1, 8'h01, 8'h00, 8'd1};
    vecs[10] = '{0, 0, 8'h00, 0, 1,   1, 0, 8'h01, 8'h00, 8'd2};
    vecs[11] = '{0, 1, 8'hFF, 0, 0,   1, 0, 8'hFF, 8'h00, 8'd2};
    vecs[12] = '{1, 1, 8'h00, 1, 1,   1, 0, 8'hFF, 8'h00, 8'd2};
    vecs[13] = '{0, 1, 8'h55, 0, 0,   1, 0, 8'h55, 8'h00, 8'd2};
    vecs[14] = '{1, 1, 8'h3C, 1, 0,   1, 0, 8'h55, 8'h00, 8'd2};
    vecs[15] = '{0, 1, 8'h55, 0, 0,   1, 0, 8'h55, 8'h00, 8'd2};
    vecs[16] = '{0, 1, 8'hAA, 1, 0,   0, 1, 8'h55, 8'hAA, 8'd2};
    vecs[17] = '{1, 0, 8'h00, 0, 0,   0, 1, 8'h55, 8'hAA, 8'd2};
    vecs[18] = '{0, 0, 8'h00, 0, 1,   1, 0, 8'h55, 8'hAA, 8'd3};
    vecs[19] = '{1, 1, 8'h12, 0, 0,   1, 0, 8'h12, 8'hAA, 8'd3};
    vecs[20] = '{0, 1, 8'h34, 1, 1,   0, 1, 8'h12, 8'h34, 8'd3};
    vecs[21] = '{0, 0, 8'h00, 0, 1,   1, 0, 8'h12, 8'h34, 8'd4};

    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0);
    step();
    step();
    rst = 1'b0;
    check_all("reset", 1, 0, 8'h00, 8'h00, 8'd0);
    check("reset.order_err", {31'd0, order_err}, 32'd0);

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].ab, vecs[i].iv, vecs[i].d, vecs[i].t, vecs[i].ordy);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].ir, vecs[i].ov, vecs[i].a, vecs[i].b,
                vecs[i].cnt);
    end

    // Back-to-back pairs at peak rate: count reaches 255 after 765 cycles, wraps at 768.
    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 768; k++) begin
      drive(0, 1, 8'(k), (k % 3) == 1, 1);
      step();
      if (k == 764) check("wrap.cnt255", {24'd0, pair_count}, 32'd255);
    end
    check("wrap.cnt0", {24'd0, pair_count}, 32'd0);
    check("wrap.in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset while holding a pair overrides abort/valid/ready and drops the pair uncounted.
    drive(0, 1, 8'h5A, 0, 0);
    step();
    drive(0, 1, 8'hA5, 1, 0);
    step();
    check_all("hold_pre_rst", 0, 1, 8'h5A, 8'hA5, 8'd0);
    rst = 1'b1;
    drive(1, 1, 8'h99, 0, 1);
    step();
    rst = 1'b0;
    drive(0, 0, 8'h00, 0, 0);
    check_all("rst_in_hold", 1, 0, 8'h00, 8'h00, 8'd0);
    check("rst_in_hold.order_err", {31'd0, order_err}, 32'd0);

    // Tag order sequence.
    drive(0, 1, 8'h11, 1, 0);
    step();
`ifdef MAJ_LOADER_ORDER_CHECK_EN
    check_all("order.bad_a", 1, 0, 8'h00, 8'h00, 8'd0);
    check("order.err_set", {31'd0, order_err}, 32'd1);
`else
    check_all("order.first", 1, 0, 8'h11, 8'h00, 8'd0);
`endif
    drive(0, 1, 8'h22, 0, 0);
    step();
    drive(0, 1, 8'h33, 1, 0);
    step();
    drive(0, 0, 8'h00, 0, 1);
`ifdef MAJ_LOADER_ORDER_CHECK_EN
    check_all("order.pair", 0, 1, 8'h22, 8'h33, 8'd0);
`else
    check_all("order.pair", 0, 1, 8'h11, 8'h22, 8'd0);
`endif
    step();
    drive(0, 0, 8'h00, 0, 0);
    check("order.delivered_cnt", {24'd0, pair_count}, 32'd1);
`ifdef MAJ_LOADER_ORDER_CHECK_EN
    check("order.err_sticky", {31'd0, order_err}, 32'd1);
`else
    check("order.err_zero", {31'd0, order_err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/majority_operand_loader.md
# majority_operand_loader

Upstream feeder for `bitwise_majority`. It accepts a byte stream over a valid/ready handshake and captures alternate beats as operand A, then operand B. It presents the completed pair as registered, stable `op_a`/`op_b` with a valid/ready handshake, so the combinational majority stage always sees a coherent pair. It also counts delivered pairs and supports a synchronous abort of a partially loaded pair.

## Interface
Parameters:
- `WIDTH`, default 8: operand width; the input beat, `op_a` and `op_b` all use this width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_data`  in  WIDTH  operand beat.
- `in_tag`  in  1  0 = beat intended as A, 1 = beat intended as B. Only used when `MAJ_LOADER_ORDER_CHECK_EN` is defined.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  loader can accept a beat.
- `abort`  in  1  discard a partially loaded pair.
- `op_a`  out  WIDTH  registered operand A to the majority stage.
- `op_b`  out  WIDTH  registered operand B to the majority stage.
- `op_valid`  out  1  `op_a`/`op_b` form a complete pair.
- `op_ready`  in  1  downstream consumes the pair.
- `pair_count`  out  8  pairs delivered; wraps.
- `order_err`  out  1  sticky tag-mismatch flag; constant 0 when the check is compiled out.

## Operation
- A beat is accepted on a cycle where `in_valid && in_ready`. A pair is delivered on a cycle where `op_valid && op_ready`.
- State machine with three states: LOAD_A, LOAD_B, HOLD. Reset state is LOAD_A.
- LOAD_A: `in_ready` = 1. On an accepted beat: `op_a` <= `in_data`, go to LOAD_B.
- LOAD_B: `in_ready` = 1. On an accepted beat: `op_b` <= `in_data`, go to HOLD.
- HOLD: `in_ready` = 0 and `op_valid` = 1. `op_a`/`op_b` are frozen. On a delivered pair: `pair_count` += 1 (mod 256), go to LOAD_A.
- `abort` in LOAD_B returns the machine to LOAD_A and discards the partial A. `op_a` keeps its stale value; `op_valid` is 0 so the stale value is not visible as a pair.
- `abort` in LOAD_B has priority over a simultaneous accepted beat: the beat is dropped and `op_b` is not written.
- `abort` in LOAD_A or HOLD is ignored. A completed pair is never discarded.
- `op_a`/`op_b` change only on their own load cycle.
- No arithmetic beyond `pair_count`, which wraps from 255 to 0 with no flag.

## Timing
- Reset values (registered outputs): `op_a` = 0, `op_b` = 0, `op_valid` = 0, `pair_count` = 0, `order_err` = 0. `in_ready` = 1 in the first cycle after reset.
- `rst` overrides `abort`, `in_valid` and `op_ready` in the same cycle. Reset during HOLD drops the pending pair without counting it.
- `in_ready` and `op_valid` are decoded from the state register only. There is no combinational path from `in_valid` or `op_ready` to any output.
- Latency: B accepted at edge N -> `op_valid` = 1 from cycle N+1.
- Delivery at edge M -> `op_valid` = 0 and `in_ready` = 1 from cycle M+1. There is no bypass while in HOLD.
- Peak throughput: one pair per 3 cycles.
- `op_valid`, once asserted, stays high with `op_a`/`op_b` stable until delivery. The only exception is `rst`.

## Configuration
- `MAJ_LOADER_ORDER_CHECK_EN` defined:
  - In LOAD_A, a beat with `in_tag` = 1 is accepted (consumed) but discarded. The state is unchanged and `order_err` is set.
  - In LOAD_B, a beat with `in_tag` = 0 is handled the same way.
  - `order_err` is sticky and is cleared only by `rst`.
- `MAJ_LOADER_ORDER_CHECK_EN` undefined: `in_tag` is ignored, beats are assigned strictly by arrival order, and `order_err` is tied to 0.

## Test plan
- Basic pair: beats 0xCC then 0xAA with `op_ready` = 1 -> `op_a` = 0xCC, `op_b` = 0xAA, `op_valid` high for one cycle starting the cycle after B is accepted, `pair_count` = 1. Downstream C = 0xEE.
- Backpressure: hold `op_ready` = 0 for 5 cycles after the pair 0x01/0x00 -> `op_valid` stays 1, `in_ready` stays 0, and `op_a`/`op_b` stay 0x01/0x00. Raise `op_ready` -> one delivery, then `in_ready` = 1 on the next cycle.
- Abort: load A = 0xFF, then assert `abort` together with a valid beat 0x00 -> no pair is formed and the machine is back in LOAD_A. The next beats 0x55/0xAA give `op_a` = 0x55, `op_b` = 0xAA.
- Wrap and reset: 256 back-to-back pairs -> `pair_count` returns to 0. Assert `rst` while in HOLD -> all outputs are at reset values on the next cycle and `pair_count` is not incremented.
- Order check (macro defined): send 0x11 with `in_tag` = 1 while in LOAD_A -> the beat is dropped and `order_err` = 1. Then 0x22 (tag 0) and 0x33 (tag 1) -> pair 0x22/0x33, and `order_err` stays 1.
- Order check (macro undefined): the same stimulus as above -> pair 0x11/0x22, and `order_err` stays 0.
